cla8_wide_seq: RTL and testbench

//   Byte-serial multi-precision add/subtract sequencer around one cla8 instance.

---
 rtl/cla8_wide_seq.sv | 178 +++++++++++++++++
 tb/tb_cla8_wide_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cla8_wide_seq.sv
// Byte-serial multi-precision add/subtract sequencer built around one 8-bit carry-lookahead adder.
// Optional zero-result flag output is enabled by defining CLA8_SEQ_ZERO_FLAG_EN.

module cla8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_s,
  output logic       o_cout
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;
  logic       w_term;
  logic       w_prop;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is the flattened lookahead sum of generate terms, not a ripple chain.
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_prop = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < 8; i++) begin
      w_term = w_g[i];
      w_prop = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_term = w_term | (w_prop & w_g[j]);
        w_prop = w_prop & w_p[j];
      end
      w_c[i+1] = w_term | (w_prop & i_cin);
    end
  end

  assign o_s    = w_p ^ w_c[7:0];
  assign o_cout = w_c[8];
endmodule

// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// a producer holds valid and data until that edge, ready may change freely.
module cla8_wide_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                overflow,
  output logic                busy,
`ifdef CLA8_SEQ_ZERO_FLAG_EN
  output logic                zero,
`endif
  output logic [1:0]          dbg_state
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_ovf;
  logic          r_zero_acc;
  logic          r_zero;

  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic [7:0]    w_s;
  logic          w_cy;
  logic          w_accept;
  logic          w_last;

  assign w_a_byte = r_a[8*r_idx +: 8];
  assign w_b_byte = r_b[8*r_idx +: 8];
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  cla8 u_cla8 (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: the inversion is folded into the captured B and the +1 into the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero_acc <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_accept) begin
      r_a        <= op_a;
      r_b        <= op_sub ? ~op_b : op_b;
      r_carry    <= op_sub;
      r_idx      <= '0;
      r_zero_acc <= 1'b1;
    end else if (r_state == RUN) begin
      r_result[8*r_idx +: 8] <= w_s;
      r_carry                <= w_cy;
      r_zero_acc             <= r_zero_acc & (w_s == 8'h00);
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_cy;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) & (w_s[7] != r_a[W-1]);
        r_zero <= r_zero_acc & (w_s == 8'h00);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;
`ifdef CLA8_SEQ_ZERO_FLAG_EN
  assign zero      = r_zero;
`else
  // Without the zero port the flag registers have no load and are trimmed away.
  logic w_zero_unused;
  assign w_zero_unused = r_zero ^ r_zero_acc;
`endif
endmodule

// File: tb/tb_cla8_wide_seq.sv
// Directed bench for cla8_wide_seq with NBYTES=4; checks are immediate assertions.

module tb_cla8_wide_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef CLA8_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cla8_wide_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy),
`ifdef CLA8_SEQ_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub);
    check({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Operands and in_valid are scrambled while busy to show they are ignored after capture.
  task automatic wait_done(input string tag);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      op_a     = W'($urandom);
      op_b     = W'($urandom);
      op_sub   = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      step();
      cycles++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(cycles), 64'(NB));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] r, input logic c,
                              input logic v, input logic z);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " result"},    64'(result),    64'(r));
    check({tag, " cout"},      64'(cout),      64'(c));
    check({tag, " overflow"},  64'(overflow),  64'(v));
`ifdef CLA8_SEQ_ZERO_FLAG_EN
    check({tag, " zero"},      64'(zero),      64'(z));
`else
    if (z === 1'bx) $display("note: %s zero flag unused", tag);
`endif
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after handshake"},  64'(in_ready),  64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] r, input logic c,
                        input logic v, input logic z);
    start_op(tag, a, b, sub);
    wait_done(tag);
    check_result(tag, r, c, v, z);
    handshake(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    #12;
    check("reset result",    64'(result),    64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset busy",      64'(busy),      64'd0);
    check("reset cout",      64'(cout),      64'd0);
    check("reset overflow",  64'(overflow),  64'd0);
    rst_n = 1'b1;
    step();

    // carry out of byte 0 into byte 1
    run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    // carry through every byte, wraps to zero
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    // subtract with and without borrow
    run_op("sub_5_7",  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5",  32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    // signed overflow in both directions
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // DONE held with out_ready low; requests during that time must be ignored
    start_op("stall", 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    wait_done("stall");
    check_result("stall", 32'hDFAE_BFF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i & 1);
      op_a     = 32'h0000_0003;
      op_b     = 32'h0000_0001;
      op_sub   = 1'b0;
      step();
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall result",    64'(result),    64'h0000_0000_DFAE_BFF0);
      check("stall in_ready",  64'(in_ready),  64'd0);
      check("stall flags",     64'({cout, overflow}), 64'd0);
    end
    in_valid = 1'b0;
    handshake("stall");
    check("stall idle after pulses", 64'(busy), 64'd0);
    run_op("sub_zero", 32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // asynchronous reset in the middle of an operation, at byte index 2
    start_op("midrst", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    step();
    step();
    check("midrst busy before reset", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst result",    64'(result),    64'd0);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy",      64'(busy),      64'd0);
    check("midrst in_ready",  64'(in_ready),  64'd1);
    check("midrst flags",     64'({cout, overflow}), 64'd0);
    check("midrst state",     64'(dbg_state), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
